// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// State encodings, opcode constants, datapath select encodings and the control-word struct.
package multicycle_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StIllegal  = 4'd11
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_DATA   = 2'b01;
    localparam logic [1:0] RESULT_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       ab_write;
        logic       data_write;
        logic       aluout_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle; master = controller, slave = datapath.
interface multicycle_ctrl_if #(
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned STATE_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                pc_write;
    logic                adr_src;
    logic                mem_write;
    logic                ir_write;
    logic                ab_write;
    logic                data_write;
    logic                aluout_write;
    logic [1:0]          result_src;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic                reg_write;
    logic                illegal;
    logic [STATE_W-1:0]  state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, ab_write, data_write, aluout_write,
        output result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, ab_write, data_write, aluout_write,
        input  result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Pure Moore state-to-control-word table; only BEQ looks at the zero flag.
module multicycle_ctrl_decode
    import multicycle_pkg::*;
(
    input  state_e state_i,
    input  logic   zero_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.ir_write   = 1'b1;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RESULT_ALU;
            end
            StDecode: begin
                // Precompute the branch/jal target while the register file is read.
                ctrl_o.alu_src_a    = SRCA_OLDPC;
                ctrl_o.alu_src_b    = SRCB_IMM;
                ctrl_o.ab_write     = 1'b1;
                ctrl_o.aluout_write = 1'b1;
            end
            StMemAdr: begin
                ctrl_o.alu_src_a    = SRCA_A;
                ctrl_o.alu_src_b    = SRCB_IMM;
                ctrl_o.aluout_write = 1'b1;
            end
            StMemRead: begin
                ctrl_o.result_src = RESULT_ALUOUT;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.data_write = 1'b1;
            end
            StMemWb: begin
                ctrl_o.result_src = RESULT_DATA;
                ctrl_o.reg_write  = 1'b1;
            end
            StMemWrite: begin
                ctrl_o.result_src = RESULT_ALUOUT;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.mem_write  = 1'b1;
            end
            StExecR: begin
                ctrl_o.alu_src_a    = SRCA_A;
                ctrl_o.alu_src_b    = SRCB_B;
                ctrl_o.alu_op       = ALUOP_FUNCT;
                ctrl_o.aluout_write = 1'b1;
            end
            StExecI: begin
                ctrl_o.alu_src_a    = SRCA_A;
                ctrl_o.alu_src_b    = SRCB_IMM;
                ctrl_o.alu_op       = ALUOP_FUNCT;
                ctrl_o.aluout_write = 1'b1;
            end
            StAluWb: begin
                ctrl_o.result_src = RESULT_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            StBeq: begin
                ctrl_o.alu_src_a  = SRCA_A;
                ctrl_o.alu_src_b  = SRCB_B;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RESULT_ALUOUT;
                ctrl_o.pc_write   = zero_i;
            end
            StJal: begin
                ctrl_o.alu_src_a    = SRCA_OLDPC;
                ctrl_o.alu_src_b    = SRCB_FOUR;
                ctrl_o.alu_op       = ALUOP_ADD;
                ctrl_o.aluout_write = 1'b1;
                ctrl_o.result_src   = RESULT_ALUOUT;
                ctrl_o.pc_write     = 1'b1;
            end
            StIllegal: ctrl_o.illegal = 1'b1;
            default:   ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I main control FSM: state register, next-state logic, output masking.
// Optional MULTICYCLE_CTRL_MEM_WAIT_EN stalls FETCH/MEMREAD/MEMWRITE until mem_ready.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    multicycle_ctrl_if.master bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl_raw, ctrl;
    logic   mem_ok;
    logic   mem_state;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_ok           = 1'b1;
`endif

    assign mem_state = (state_q == StFetch) || (state_q == StMemRead) ||
                       (state_q == StMemWrite);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: if (mem_ok) state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_R:         state_d = StExecR;
                    OP_I:         state_d = StExecI;
                    OP_BEQ:       state_d = StBeq;
                    OP_JAL:       state_d = StJal;
                    default:      state_d = StIllegal;
                endcase
            end
            StMemAdr:   state_d = (bus.opcode == OP_LW) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ok) state_d = StMemWb;
            StMemWrite: if (mem_ok) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StMemWb, StAluWb, StBeq, StIllegal: state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state_i (state_q),
        .zero_i  (bus.zero),
        .ctrl_o  (ctrl_raw)
    );

    // Strobes fire only on the cycle the memory accepts; reset blanks everything.
    always_comb begin
        ctrl = ctrl_raw;
        if (mem_state && !mem_ok) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ir_write   = 1'b0;
            ctrl.data_write = 1'b0;
            ctrl.mem_write  = 1'b0;
        end
        if (!resetn) begin
            ctrl = '0;
        end
    end

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.adr_src      = ctrl.adr_src;
    assign bus.mem_write    = ctrl.mem_write;
    assign bus.ir_write     = ctrl.ir_write;
    assign bus.ab_write     = ctrl.ab_write;
    assign bus.data_write   = ctrl.data_write;
    assign bus.aluout_write = ctrl.aluout_write;
    assign bus.result_src   = ctrl.result_src;
    assign bus.alu_src_a    = ctrl.alu_src_a;
    assign bus.alu_src_b    = ctrl.alu_src_b;
    assign bus.alu_op       = ctrl.alu_op;
    assign bus.reg_write    = ctrl.reg_write;
    assign bus.illegal      = ctrl.illegal;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver pushes per-cycle expectations, negedge monitor checks.
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] v;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_vec;
    assign dut_vec = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.ab_write,
                      bus.data_write, bus.aluout_write, bus.result_src, bus.alu_src_a,
                      bus.alu_src_b, bus.alu_op, bus.reg_write, bus.illegal};

    // Hand-written output table: {pc,adr,mw,ir,ab,dw,aw,rs,sa,sb,op,rw,il}
    function automatic logic [16:0] exp_out(state_e st, logic z, logic mr);
        logic [16:0] v;
        case (st)
            StFetch:    v = {7'b1001000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
            StDecode:   v = {7'b0000101, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
            StMemAdr:   v = {7'b0000001, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
            StMemRead:  v = {7'b0100010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
            StMemWb:    v = {7'b0000000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
            StMemWrite: v = {7'b0110000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
            StExecR:    v = {7'b0000001, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
            StExecI:    v = {7'b0000001, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
            StAluWb:    v = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
            StBeq:      v = {z, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
            StJal:      v = {7'b1000001, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
            StIllegal:  v = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
            default:    v = '0;
        endcase
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        if (!mr && (st == StFetch || st == StMemRead || st == StMemWrite)) begin
            v[16] = 1'b0;
            v[14] = 1'b0;
            v[13] = 1'b0;
            v[11] = 1'b0;
        end
`else
        if (mr === 1'bx) v = 'x;
`endif
        return v;
    endfunction

    task automatic check(input string nm, input logic [3:0] st, input logic [16:0] v);
        total++;
        if (bus.state_o !== st || dut_vec !== v) begin
            bad++;
            $display("FAIL %s: got state=%0d out=%b, want state=%0d out=%b",
                     nm, bus.state_o, dut_vec, st, v);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.nm, e.st, e.v);
        end
    end

    task automatic tick(input logic [6:0] op, input state_e st, input logic z, input logic mr,
                        input logic rn, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = mr;
        resetn        = rn;
        e.nm = nm;
        if (rn) begin
            e.st = st;
            e.v  = exp_out(st, z, mr);
        end else begin
            e.st = StFetch;
            e.v  = '0;
        end
        sb_q.push_back(e);
    endtask

    task automatic t(input logic [6:0] op, input state_e st, input string nm);
        tick(op, st, 1'b0, 1'b1, 1'b1, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bus.opcode    = 7'b0000011;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        e.st = StFetch; e.v = '0; e.nm = "reset";
        sb_q.push_back(e);
        @(negedge clk);

        t(7'b0000011, StFetch,   "lw_fetch");
        t(7'b0000011, StDecode,  "lw_decode");
        t(7'b0000011, StMemAdr,  "lw_memadr");
        t(7'b0000011, StMemRead, "lw_memread");
        t(7'b0000011, StMemWb,   "lw_memwb");

        t(7'b1100011, StFetch,  "beq1_fetch");
        t(7'b1100011, StDecode, "beq1_decode");
        tick(7'b1100011, StBeq, 1'b1, 1'b1, 1'b1, "beq_taken");

        tick(7'b1100011, StFetch,  1'b1, 1'b1, 1'b1, "beq0_fetch");
        tick(7'b1100011, StDecode, 1'b1, 1'b1, 1'b1, "beq0_decode");
        tick(7'b1100011, StBeq,    1'b0, 1'b1, 1'b1, "beq_not_taken");

        t(7'b0100011, StFetch,    "sw_fetch");
        t(7'b0100011, StDecode,   "sw_decode");
        t(7'b0100011, StMemAdr,   "sw_memadr");
        t(7'b0100011, StMemWrite, "sw_memwrite");

        t(7'b1111111, StFetch,   "ill_fetch");
        t(7'b1111111, StDecode,  "ill_decode");
        t(7'b1111111, StIllegal, "ill_pulse");

        t(7'b0110011, StFetch,  "r_fetch");
        t(7'b0110011, StDecode, "r_decode");
        t(7'b0110011, StExecR,  "r_exec");
        t(7'b0110011, StAluWb,  "r_wb");

        t(7'b0010011, StFetch,  "i_fetch");
        t(7'b0010011, StDecode, "i_decode");
        t(7'b0010011, StExecI,  "i_exec");
        t(7'b0010011, StAluWb,  "i_wb");

        t(7'b1101111, StFetch,  "jal_fetch");
        t(7'b1101111, StDecode, "jal_decode");
        t(7'b1101111, StJal,    "jal_jump");
        t(7'b1101111, StAluWb,  "jal_wb");

        // Abandon a load mid-MEMREAD with an asynchronous reset.
        t(7'b0000011, StFetch,   "rlw_fetch");
        t(7'b0000011, StDecode,  "rlw_decode");
        t(7'b0000011, StMemAdr,  "rlw_memadr");
        t(7'b0000011, StMemRead, "rlw_memread");
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_async_zero", StFetch, '0);
        tick(7'b0000011, StFetch, 1'b0, 1'b1, 1'b0, "rst_held");
        t(7'b0100011, StFetch,    "post_rst_fetch");
        t(7'b0100011, StDecode,   "post_rst_decode");
        t(7'b0100011, StMemAdr,   "post_rst_memadr");
        t(7'b0100011, StMemWrite, "post_rst_memwrite");

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        tick(7'b0110011, StFetch, 1'b0, 1'b0, 1'b1, "wait_fetch1");
        tick(7'b0110011, StFetch, 1'b0, 1'b0, 1'b1, "wait_fetch2");
        tick(7'b0110011, StFetch, 1'b0, 1'b0, 1'b1, "wait_fetch3");
        tick(7'b0110011, StFetch, 1'b0, 1'b1, 1'b1, "wait_fetch_go");
`else
        tick(7'b0110011, StFetch, 1'b0, 1'b0, 1'b1, "nowait_fetch");
`endif
        t(7'b0110011, StDecode, "wr_decode");
        t(7'b0110011, StExecR,  "wr_exec");
        t(7'b0110011, StAluWb,  "wr_wb");
        t(7'b0000011, StFetch,  "final_fetch");

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared datapath registers (IR/OldPC, data, RD1/RD2 "A/B", ALUOut) through fetch/decode/execute/memory/writeback.
- Drives the mux selects and write enables for the PC, register file, memory and ALU.
- Supports lw, sw, R-type, I-type ALU, beq and jal. Anything else is flagged illegal and skipped.

Parameters:
- OPCODE_W, 7, opcode field width (instr[6:0]).
- STATE_W, 4, state register width; must hold 12 states.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- opcode  input  OPCODE_W  instr[6:0] from IR; valid from Decode onward.
- zero  input  1  ALU zero flag (combinational from the current ALU op).
- mem_ready  input  1  memory handshake; used only when MULTICYCLE_CTRL_MEM_WAIT_EN is defined, ignored otherwise.
- pc_write  output  1  PC enable (unconditional or branch-taken).
- adr_src  output  1  memory address select: 0 = PC, 1 = Result.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  load IR and OldPC.
- ab_write  output  1  load RD1/RD2 registers.
- data_write  output  1  load memory data register.
- aluout_write  output  1  load ALUOut.
- result_src  output  2  00 = ALUOut, 01 = data reg, 10 = ALU result.
- alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = A.
- alu_src_b  output  2  00 = B, 01 = ImmExt, 10 = constant 4.
- alu_op  output  2  00 = add, 01 = sub, 10 = decode funct3/funct7.
- reg_write  output  1  register file write.
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- state_o  output  STATE_W  current state, for debug.

Behaviour:
- State register updates on posedge clk. resetn low forces FETCH asynchronously.
- All outputs are a Moore decode of state only, except pc_write in BEQ (= zero).
- Under reset, every output is 0 and state_o = FETCH; the FETCH strobes are masked while resetn = 0.
- Unlisted outputs are 0 in every state.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_write=1. Next: DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, ab_write=1, aluout_write=1 (branch/jal target). Next by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00, aluout_write=1. Next: MEMREAD if opcode = lw, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1, data_write=1. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, aluout_write=1. Next: ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, aluout_write=1. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Next: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, aluout_write=1, result_src=00, pc_write=1. Next: ALUWB (writes PC+4 to rd).
- ILLEGAL: illegal=1. Next: FETCH. The PC has already advanced, so the instruction is skipped.
- Instruction latencies, FETCH to next FETCH:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
  - illegal: 3 cycles
- The 4 unused state encodings return to FETCH on the next clock.
- Reset asserted mid-instruction abandons it immediately; no partial register-file write follows.
- The opcode is sampled only in DECODE and MEMADR; IR must be stable until the next FETCH.

Optional Feature:
- Macro: MULTICYCLE_CTRL_MEM_WAIT_EN.
- Defined:
  - FETCH, MEMREAD and MEMWRITE hold their state and outputs until mem_ready = 1.
  - Write enables (pc_write, ir_write, data_write, mem_write) assert only in the cycle where mem_ready = 1.
  - Each wait cycle adds one cycle of latency.
- Undefined: mem_ready is ignored and every memory access completes in one cycle.

Decomposition:
- Package multicycle_pkg holds:
  - state encodings
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - select encodings: RESULT_*, SRCA_*, SRCB_*, ALUOP_*
- One natural sub-module: multicycle_ctrl_decode, the pure combinational state-to-outputs table.
- The next-state logic and state register stay in multicycle_ctrl.

Test Plan:
- Reset, then opcode=0000011 (lw) -> state_o: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; reg_write=1 only in cycle 5, result_src=01.
- opcode=1100011 (beq), zero=1 -> pc_write=1 in cycle 3, back to FETCH. Repeat with zero=0 -> pc_write=0 in cycle 3.
- opcode=0100011 (sw) -> mem_write=1 only in cycle 4, adr_src=1; reg_write never asserts.
- opcode=1111111 -> illegal pulses for exactly 1 cycle in cycle 3, then FETCH; reg_write and mem_write stay 0.
- resetn dropped asynchronously during MEMREAD of lw -> outputs 0 immediately; after release, state_o=FETCH and no reg_write occurs.
- With MULTICYCLE_CTRL_MEM_WAIT_EN, R-type with mem_ready low for 3 FETCH cycles -> ir_write and pc_write assert only in cycle 4; total latency 7 cycles.
